// File: rtl/clas_share_arbiter.sv
// clas_share_arbiter: round-robin front end for one shared WIDTH-bit
// carry-lookahead add/sub unit. Accepts one operation from one of two
// requesters, drives the adder for a cycle, captures sum/carry/overflow
// and returns it on a valid/ready response channel tagged with the id.
module clas_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_w,
    input  logic [WIDTH-1:0] alu_sum,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_cout,
    output logic             rsp_ovf,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state;
    logic   last_grant;
    logic   lat_id;
    logic   grant0;
    logic   grant1;
    logic   ovf;

    // Round-robin winner selection; grants only exist while idle.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && (!req1_valid || last_grant)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Signed overflow: effective operand signs agree but the result sign differs from a.
    always_comb begin
        ovf = (alu_a[WIDTH-1] == (alu_b[WIDTH-1] ^ alu_w)) &&
              (alu_sum[WIDTH-1] != alu_a[WIDTH-1]);
    end

    // Control FSM with registered adder operands and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            lat_id     <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_w      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_cout   <= 1'b0;
            rsp_ovf    <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0) begin
                        alu_a      <= req0_a;
                        alu_b      <= req0_b;
                        alu_w      <= req0_op;
                        lat_id     <= 1'b0;
                        last_grant <= 1'b0;
                        state      <= EXEC;
                    end else if (grant1) begin
                        alu_a      <= req1_a;
                        alu_b      <= req1_b;
                        alu_w      <= req1_op;
                        lat_id     <= 1'b1;
                        last_grant <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_sum;
                    rsp_cout  <= alu_cout;
                    rsp_ovf   <= ovf;
                    rsp_id    <= lat_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (op_count != '1) begin
                            op_count <= op_count + CNT_W'(1);
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clas_share_arbiter.sv
// Directed bench for clas_share_arbiter with a behavioural adder model.
module tb_clas_share_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready, req0_op;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_op;
    logic [31:0] req1_a, req1_b;
    logic [31:0] alu_a, alu_b, alu_sum;
    logic        alu_w, alu_cout;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf;
    logic [31:0] rsp_data;
    logic [15:0] op_count;
    logic [32:0] full;

    int checks   = 0;
    int failures = 0;
    int exp_count = 0;

    clas_share_arbiter #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_w(alu_w),
        .alu_sum(alu_sum), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
        .op_count(op_count)
    );

    // External adder: a + b or a + ~b + 1, carry from bit 32.
    always_comb begin
        full     = alu_w ? ({1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1)
                         : ({1'b0, alu_a} + {1'b0, alu_b});
        alu_sum  = full[31:0];
        alu_cout = full[32];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One operation from a single requester with rsp_ready held high.
    task automatic do_op(input bit id, input bit op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ed, input bit ec, input bit eo);
        if (!id) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
        #1;
        chk("ready_winner", id ? req1_ready : req0_ready, 1);
        chk("ready_other",  id ? req0_ready : req1_ready, 0);
        tick;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("exec_no_valid", rsp_valid, 0);
        chk("alu_a", alu_a, a);
        chk("alu_b", alu_b, b);
        chk("alu_w", alu_w, op);
        tick;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_data", rsp_data, ed);
        chk("rsp_cout", rsp_cout, ec);
        chk("rsp_ovf", rsp_ovf, eo);
        chk("rsp_id", rsp_id, id);
        tick;
        exp_count++;
        chk("rsp_drop", rsp_valid, 0);
        chk("op_count", op_count, exp_count);
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_op = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = 1'b0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_ready", {req0_ready, req1_ready}, 0);

        do_op(1'b0, 1'b0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0);
        do_op(1'b1, 1'b1, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0);
        do_op(1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
        do_op(1'b1, 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1);
        do_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);

        // Fairness: both valid continuously, last grant was requester 1.
        req0_valid = 1'b1; req0_op = 1'b0; req0_a = 32'd10; req0_b = 32'd1;
        req1_valid = 1'b1; req1_op = 1'b1; req1_a = 32'd20; req1_b = 32'd2;
        #1;
        for (int k = 0; k < 18; k++) begin
            if (k % 3 == 0) begin
                chk("rr_ready0", req0_ready, ((k / 3) % 2 == 0) ? 1 : 0);
                chk("rr_ready1", req1_ready, ((k / 3) % 2 == 1) ? 1 : 0);
            end else begin
                chk("rr_busy_ready", {req0_ready, req1_ready}, 0);
            end
            if (k % 3 == 2) begin
                chk("rr_rsp_valid", rsp_valid, 1);
                chk("rr_rsp_id", rsp_id, (k / 3) % 2);
                chk("rr_rsp_data", rsp_data, ((k / 3) % 2 == 0) ? 32'd11 : 32'd18);
            end
            tick;
        end
        exp_count += 6;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("rr_op_count", op_count, exp_count);

        // Backpressure then reset in RESP.
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 1'b0; req0_a = 32'h1234_5678; req0_b = 32'h1111_1111;
        #1;
        chk("bp_accept", req0_ready, 1);
        tick;
        tick;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_valid", rsp_valid, 1);
            chk("bp_data", rsp_data, 32'h2345_6789);
            chk("bp_id", rsp_id, 0);
            chk("bp_flags", {rsp_cout, rsp_ovf}, 0);
            chk("bp_no_ready", {req0_ready, req1_ready}, 0);
            tick;
        end
        chk("bp_count_held", op_count, exp_count);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        chk("rr_rst_valid", rsp_valid, 0);
        chk("rr_rst_count", op_count, 0);
        chk("rr_rst_ready0", req0_ready, 1);
        chk("rr_rst_ready1", req1_ready, 0);
        rsp_ready = 1'b1;
        tick;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick;
        chk("post_rst_valid", rsp_valid, 1);
        chk("post_rst_id", rsp_id, 0);
        chk("post_rst_data", rsp_data, 32'h2345_6789);
        tick;
        chk("post_rst_count", op_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clas_share_arbiter.md
Name: clas_share_arbiter

Overview:
- Shares one external 32-bit carry-lookahead adder/subtracter between two requesters. The adder has a combinational path: operands in, sum and carry out.
- Arbitrates round-robin, registers the winner's operands, and drives the adder's a, b and w (0 = add, 1 = subtract).
- Captures sum, carry-out and signed overflow, and returns them on a single valid/ready response channel tagged with the requester id.
- Sits between requesting datapath blocks and the shared add/sub unit.

Parameters:
- WIDTH, 32, operand/result width; must equal the adder width.
- CNT_W, 16, width of the saturating completed-operation counter.

Ports:
- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  synchronous reset, active-high
- req0_valid  input  1  requester 0 has an operation pending
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_op  input  1  0 = a+b, 1 = a-b
- req0_a  input  WIDTH  operand a
- req0_b  input  WIDTH  operand b
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as above, for requester 1
- alu_a  output  WIDTH  adder operand a
- alu_b  output  WIDTH  adder operand b
- alu_w  output  1  adder add/sub select
- alu_sum  input  WIDTH  adder sum; combinational in alu_a/alu_b/alu_w
- alu_cout  input  1  adder carry-out
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes result
- rsp_id  output  1  requester that issued the result
- rsp_data  output  WIDTH  result
- rsp_cout  output  1  carry-out; for subtract, 1 = no borrow (a >= b unsigned)
- rsp_ovf  output  1  signed two's-complement overflow
- op_count  output  CNT_W  completed responses, saturating at all-ones

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE.
  - All outputs 0: rsp_*, alu_*, op_count.
  - last_grant=1, so requester 0 wins the first tie.
  - Reset wins over every other event, including mid-EXEC and mid-RESP; the in-flight operation is dropped and no response is issued.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Winner selection:
    - Only req0_valid high: requester 0 wins.
    - Only req1_valid high: requester 1 wins.
    - Both high: the requester other than last_grant wins.
  - reqN_ready=1 combinationally only for the winner, only in IDLE; ready is never high for both.
  - On acceptance (valid&&ready at edge T):
    - Latch op, a, b and id.
    - last_grant <= winner id.
    - Next state EXEC.
  - No valid: stay in IDLE.
- EXEC (cycle T+1):
  - alu_a, alu_b, alu_w come from the latched registers; they are held stable from T+1 until the next acceptance.
  - At the end of T+1, capture rsp_data<=alu_sum, rsp_cout<=alu_cout and rsp_id.
  - Overflow rule:
    - rsp_ovf = (a[W-1] == (b[W-1]^op)) && (alu_sum[W-1] != a[W-1]).
    - Equivalent forms: add, same operand signs with a sum sign that differs; subtract, different operand signs with a sum sign that differs from a.
  - Next state RESP.
- RESP:
  - rsp_valid=1 from cycle T+2.
  - rsp_data, rsp_cout, rsp_ovf and rsp_id are held stable while rsp_valid && !rsp_ready.
  - On rsp_valid&&rsp_ready:
    - rsp_valid <= 0.
    - op_count += 1, unless op_count is all-ones.
    - Next state IDLE.
  - rsp_data and the flags hold their last value after the handshake.
- Latency: acceptance edge to rsp_valid = 2 cycles.
- Throughput: at most one operation per 3 cycles (IDLE, EXEC, RESP) with rsp_ready tied high.
- No new request is accepted during EXEC or RESP; reqN_ready=0.
- Requesters hold valid and operands until ready. A requester that drops valid before acceptance loses no state.
- Arithmetic wraps modulo 2^WIDTH. No result is truncated or extended.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,...

Test Plan:
- After reset:
  - req0: op=0, a=0x0000_0005, b=0x0000_0003.
  - Expect req0_ready in the same cycle and rsp_valid 2 cycles later.
  - Response: rsp_id=0, rsp_data=0x0000_0008, rsp_cout=0, rsp_ovf=0; op_count=1 after the handshake.
- req1, op=1, a=0x0000_0003, b=0x0000_0005:
  - rsp_data=0xFFFF_FFFE, rsp_cout=0 (borrow), rsp_ovf=0, rsp_id=1.
- Signed overflow:
  - add 0x7FFF_FFFF+0x0000_0001 -> rsp_data=0x8000_0000, rsp_ovf=1, rsp_cout=0.
  - sub 0x8000_0000-0x0000_0001 -> rsp_data=0x7FFF_FFFF, rsp_ovf=1, rsp_cout=1.
- Carry:
  - add 0xFFFF_FFFF+0x0000_0001 -> rsp_data=0, rsp_cout=1, rsp_ovf=0.
- Both valid continuously for 6 operations, rsp_ready=1:
  - Grant order 0,1,0,1,0,1.
  - One acceptance every 3 cycles; ready never high on both.
- Backpressure and reset:
  - Hold rsp_ready=0 for 5 cycles: rsp_* stable, no reqN_ready.
  - Assert rst during RESP: next cycle rsp_valid=0, op_count=0, state IDLE.
  - Then with both valid, requester 0 wins.
